// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared FSM states and command codes for the SPI slave
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    TX
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // A write state accepts either write command; each read state accepts only its own code.
  function automatic logic cmd_legal(input state_e st, input logic [1:0] cmd);
    case (st)
      WRITE:     cmd_legal = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
      READ_ADD:  cmd_legal = (cmd == CMD_RD_ADDR);
      READ_DATA: cmd_legal = (cmd == CMD_RD_DATA);
      default:   cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - parallel-to-serial MSB-first shifter driving a registered MISO
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              miso_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              miso_q;

  // Load latches the byte with MISO still low; each later edge drives one bit, then MISO returns to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      miso_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      miso_q <= 1'b0;
    end else if (load_i) begin
      sreg_q <= data_i;
      cnt_q  <= CNT_W'(DATA_W);
      miso_q <= 1'b0;
    end else if (shift_i && (cnt_q != '0)) begin
      miso_q <= sreg_q[DATA_W-1];
      sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
      cnt_q  <= cnt_q - CNT_W'(1);
    end else begin
      miso_q <= 1'b0;
    end
  end

  assign miso_o = miso_q;
  assign busy_o = (cnt_q != '0);
  // High on the edge that drives the final bit.
  assign done_o = shift_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/spi_slave_gen2.sv
// rtl/spi_slave_gen2.sv - clk-sampled SPI slave with read/write framing; SPI_SLAVE_ASSERT_EN adds assertions
module spi_slave_gen2
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  state_e              state_q, state_d;
  logic [FRAME_W-2:0]  shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                rd_addr_next_q, rd_addr_next_d;
  logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;

  logic                tx_load, tx_clear, tx_busy, tx_done, tx_shift;
  logic [FRAME_W-1:0]  frame;

  // Full frame as it would be if the bit sampled on this edge were the last one.
  assign frame    = {shift_q, MOSI};
  assign tx_shift = (state_q == TX);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      rd_addr_next_q <= 1'b1;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      rd_addr_next_q <= rd_addr_next_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // Next state: SS_n high outranks everything, including a frame's final bit.
  // done_q marks a frame already closed (accepted or already flagged), after which bits are ignored.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    done_d         = done_q;
    rd_addr_next_d = rd_addr_next_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    tx_load        = 1'b0;
    tx_clear       = 1'b0;
    if (state_q == IDLE) begin
      if (!SS_n) begin
        state_d = CHK_CMD;
        cnt_d   = '0;
        done_d  = 1'b0;
      end
    end else if (SS_n) begin
      state_d     = IDLE;
      cnt_d       = '0;
      tx_clear    = 1'b1;
      frame_err_d = !(done_q && !tx_busy);
    end else begin
      case (state_q)
        CHK_CMD: begin
          shift_d = {{(FRAME_W-2){1'b0}}, MOSI};
          cnt_d   = CNT_W'(1);
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_next_q) state_d = READ_ADD;
          else                     state_d = READ_DATA;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!done_q) begin
            shift_d = {shift_q[FRAME_W-3:0], MOSI};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              done_d = 1'b1;
              if (cmd_legal(state_q, frame[FRAME_W-1 -: 2])) begin
                rx_data_d  = frame;
                rx_valid_d = 1'b1;
                if (state_q == READ_ADD)  rd_addr_next_d = 1'b0;
                if (state_q == READ_DATA) state_d = TX;
              end else begin
                frame_err_d = 1'b1;
              end
            end
          end
        end
        TX: begin
          if (tx_valid && !tx_busy) tx_load = 1'b1;
          if (tx_done) rd_addr_next_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tx_load),
    .shift_i (tx_shift),
    .clear_i (tx_clear),
    .data_i  (tx_data),
    .miso_o  (MISO),
    .busy_o  (tx_busy),
    .done_o  (tx_done)
  );

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

`ifdef SPI_SLAVE_ASSERT_EN
  a_rst_idle:   assert property (@(posedge clk) rst |-> state_q == IDLE);
  a_ss_rise:    assert property (@(posedge clk) disable iff (rst) $rose(SS_n) |=> state_q == IDLE);
  a_excl:       assert property (@(posedge clk) disable iff (rst) !(rx_valid && frame_err));
  a_rv_single:  assert property (@(posedge clk) disable iff (rst) rx_valid |=> !rx_valid);
`else
`endif

endmodule
